// File: rtl/brc_arb.sv
// Arbiter/sequencer for the shared execute-stage branch comparator: grants it to the
// branch unit or the SLT unit each cycle, registers the results and keeps branch statistics.

module brc (
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        sgn,
   output logic        eq,
   output logic        less
);

   assign eq   = (a == b);
   assign less = sgn ? ($signed(a) < $signed(b)) : (a < b);

endmodule

module brc_arb #(
   parameter int CNT_W      = 16,
   parameter int STARVE_MAX = 3
) (
   input  logic             i_clk,
   input  logic             i_rst_n,

   input  logic             i_br_valid,
   output logic             o_br_ready,
   input  logic [2:0]       i_br_funct3,
   input  logic [31:0]      i_br_rs1,
   input  logic [31:0]      i_br_rs2,
   input  logic [31:0]      i_br_pc,
   input  logic [31:0]      i_br_imm,
   output logic             o_br_rsp_valid,
   output logic             o_br_taken,
   output logic [31:0]      o_br_target,
   output logic             o_br_flush,
   output logic             o_br_illegal,

   input  logic             i_slt_valid,
   output logic             o_slt_ready,
   input  logic             i_slt_un,
   input  logic [31:0]      i_slt_rs1,
   input  logic [31:0]      i_slt_rs2,
   output logic             o_slt_rsp_valid,
   output logic [31:0]      o_slt_rd,

   output logic [CNT_W-1:0] o_br_cnt,
   output logic [CNT_W-1:0] o_taken_cnt
);

   localparam int            STARVE_W   = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
   localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

   logic [STARVE_W-1:0] starve_cnt;
   logic                force_slt;
   logic                br_grant;
   logic                slt_grant;

   logic [31:0]         cmp_a;
   logic [31:0]         cmp_b;
   logic                cmp_sgn;
   logic                cmp_eq;
   logic                cmp_less;

   logic                br_taken_d;
   logic                br_illegal_d;

   // Branch wins by fixed priority unless SLT has been denied STARVE_MAX cycles in a row.
   assign force_slt   = (starve_cnt == STARVE_LIM) & i_slt_valid;
   assign o_br_ready  = ~force_slt;
   assign o_slt_ready = force_slt | ~i_br_valid;
   assign br_grant    = i_br_valid & o_br_ready;
   assign slt_grant   = i_slt_valid & o_slt_ready;

   // Operand mux: when nobody is granted the SLT side drives the comparator harmlessly.
   assign cmp_a   = br_grant ? i_br_rs1 : i_slt_rs1;
   assign cmp_b   = br_grant ? i_br_rs2 : i_slt_rs2;
   assign cmp_sgn = br_grant ? ~i_br_funct3[1] : ~i_slt_un;

   brc u_brc (
      .a    (cmp_a),
      .b    (cmp_b),
      .sgn  (cmp_sgn),
      .eq   (cmp_eq),
      .less (cmp_less)
   );

   // NOTE: both outputs get a default before the case so no latch is inferred.
   always_comb begin
      br_taken_d   = 1'b0;
      br_illegal_d = 1'b0;
      case (i_br_funct3)
         3'b000:          br_taken_d   = cmp_eq;
         3'b001:          br_taken_d   = ~cmp_eq;
         3'b100, 3'b110:  br_taken_d   = cmp_less;
         3'b101, 3'b111:  br_taken_d   = ~cmp_less;
         default:         br_illegal_d = 1'b1;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         starve_cnt <= '0;
      end else if (!i_slt_valid || slt_grant) begin
         starve_cnt <= '0;
      end else if (starve_cnt != STARVE_LIM) begin
         starve_cnt <= starve_cnt + STARVE_W'(1);
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_br_rsp_valid  <= 1'b0;
         o_br_taken      <= 1'b0;
         o_br_flush      <= 1'b0;
         o_br_illegal    <= 1'b0;
         o_slt_rsp_valid <= 1'b0;
      end else begin
         o_br_rsp_valid  <= br_grant;
         o_br_taken      <= br_grant & br_taken_d;
         o_br_flush      <= br_grant & br_taken_d;
         o_br_illegal    <= br_grant & br_illegal_d;
         o_slt_rsp_valid <= slt_grant;
      end
   end

   // Target and rd hold their last value between responses.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_br_target <= '0;
         o_slt_rd    <= '0;
      end else begin
         if (br_grant)
            o_br_target <= i_br_pc + i_br_imm;
         if (slt_grant)
            o_slt_rd <= {31'b0, cmp_less};
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_br_cnt    <= '0;
         o_taken_cnt <= '0;
      end else if (br_grant) begin
         o_br_cnt <= o_br_cnt + CNT_W'(1);
         if (br_taken_d)
            o_taken_cnt <= o_taken_cnt + CNT_W'(1);
      end
   end

endmodule
